// File: rtl/tty_iobus.sv
// Console teletype on the KA10 I/O bus: CONO/CONI/DATAO/DATAI decode,
// 8N1 serial transmitter, parallel receive latch and PI request generation.
module tty_iobus #(
  parameter logic [6:0]  DEVSEL = 7'o24,
  parameter int unsigned CLKDIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iobus_iob_reset,
  input  logic [3:9]  iobus_ios,
  input  logic        iobus_datao_clear,
  input  logic        iobus_datao_set,
  input  logic        iobus_cono_clear,
  input  logic        iobus_cono_set,
  input  logic        iobus_iob_datai,
  input  logic        iobus_iob_coni,
  input  logic [0:35] iobus_iob_in,
  output logic [0:35] iobus_iob_out,
  output logic [1:7]  iobus_pi,
  output logic        tx_line,
  input  logic [0:7]  rx_data,
  input  logic        rx_strobe
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKDIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // Bus and device state
  logic             clr;
  logic             sel;
  logic             cono_clr_c;
  logic             cono_set_c;
  logic             datao_clr_c;
  logic             datao_set_c;
  logic             datai_lvl_c;
  logic             coni_lvl_c;
  logic             datai_q;
  logic             datai_rise_c;

  logic [2:0]       pia;
  logic             tto_busy;
  logic             tto_done;
  logic             tti_done;
  logic [28:35]     tto_buf;
  logic [0:7]       tti_buf;
  logic             start_req;

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shifter;
  logic [2:0]       bitn;
  logic             tx_start_c;
  logic             tx_end_c;

  logic             unused_iob;

  // Strobe qualification: everything on the bus is gated by device select
  assign clr          = reset | iobus_iob_reset;
  assign sel          = (iobus_ios == DEVSEL);
  assign cono_clr_c   = iobus_cono_clear & sel;
  assign cono_set_c   = iobus_cono_set & sel;
  assign datao_clr_c  = iobus_datao_clear & sel;
  assign datao_set_c  = iobus_datao_set & sel;
  assign datai_lvl_c  = iobus_iob_datai & sel;
  assign coni_lvl_c   = iobus_iob_coni & sel;
  assign datai_rise_c = datai_lvl_c & ~datai_q;

  // A start only launches from an idle transmitter; a busy one drops it
  assign tx_start_c = start_req & ~tto_busy;
  assign tx_end_c   = (state == ST_STOP) && (cnt == '0);

  assign unused_iob = ^{iobus_iob_in[0:27], iobus_iob_in[30], iobus_iob_in[32]};

  // DATAI edge detector so only the first read cycle clears tti_done
  always_ff @(posedge clk) begin
    if (clr) begin
      datai_q <= 1'b0;
    end else begin
      datai_q <= datai_lvl_c;
    end
  end

  // Interrupt assignment: clear applies before set in the same cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      pia <= 3'd0;
    end else begin
      pia <= (cono_clr_c ? 3'd0 : pia) |
             (cono_set_c ? iobus_iob_in[33:35] : 3'd0);
    end
  end

  // Transmit buffer and one-cycle start request from DATAO set
  always_ff @(posedge clk) begin
    if (clr) begin
      tto_buf   <= '0;
      start_req <= 1'b0;
    end else begin
      tto_buf   <= (datao_clr_c ? 8'd0 : tto_buf) |
                   (datao_set_c ? iobus_iob_in[28:35] : 8'd0);
      start_req <= datao_set_c;
    end
  end

  // Output-done flag: clears first, then sets; character completion always wins
  always_ff @(posedge clk) begin
    if (clr) begin
      tto_done <= 1'b0;
    end else begin
      tto_done <= ((cono_clr_c | datao_clr_c) ? 1'b0 : tto_done) |
                  (cono_set_c & iobus_iob_in[31]) |
                  tx_end_c;
    end
  end

  // Input-done flag: a receive strobe beats the DATAI clear in the same cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      tti_done <= 1'b0;
    end else begin
      tti_done <= ((cono_clr_c | datai_rise_c) ? 1'b0 : tti_done) |
                  (cono_set_c & iobus_iob_in[29]) |
                  rx_strobe;
    end
  end

  // Receive buffer: every strobe overwrites, overrun included
  always_ff @(posedge clk) begin
    if (clr) begin
      tti_buf <= '0;
    end else if (rx_strobe) begin
      tti_buf <= rx_data;
    end
  end

  // Serial transmitter: START, 8 data bits LSB first, STOP, each CLKDIV cycles
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shifter  <= '0;
      bitn     <= 3'd0;
      tto_busy <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_line <= 1'b1;
          if (tx_start_c) begin
            state    <= ST_START;
            cnt      <= CNT_RELOAD;
            shifter  <= tto_buf;
            tto_busy <= 1'b1;
            tx_line  <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            state   <= ST_DATA;
            cnt     <= CNT_RELOAD;
            bitn    <= 3'd0;
            tx_line <= shifter[0];
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            cnt <= CNT_RELOAD;
            if (bitn == 3'd7) begin
              state   <= ST_STOP;
              tx_line <= 1'b1;
            end else begin
              bitn    <= bitn + 3'd1;
              shifter <= shifter >> 1;
              tx_line <= shifter[1];
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt == '0) begin
            state    <= ST_IDLE;
            tto_busy <= 1'b0;
            tx_line  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          tto_busy <= 1'b0;
          tx_line  <= 1'b1;
        end
      endcase
    end
  end

  // PI request: one-hot on the assigned level while either flag is up
  always_ff @(posedge clk) begin
    if (clr) begin
      iobus_pi <= '0;
    end else begin
      for (int n = 1; n <= 7; n++) begin
        iobus_pi[n] <= (pia == 3'(n)) && (tto_done | tti_done);
      end
    end
  end

  // Read-back mux onto the wired-OR bus; zero unless selected and reading
  always_comb begin
    iobus_iob_out = '0;
    if (coni_lvl_c) begin
      iobus_iob_out[29]    = tti_done;
      iobus_iob_out[30]    = tto_busy;
      iobus_iob_out[31]    = tto_done;
      iobus_iob_out[33:35] = pia;
    end
    if (datai_lvl_c) begin
      iobus_iob_out[28:35] = iobus_iob_out[28:35] | tti_buf;
    end
  end

endmodule
